module_keypad_scanner: RTL and testbench
========================================

Name: module_keypad_scanner

Overview:
- Front end of the 4x4 hex keypad path. Drives the keypad columns one at a time and samples the rows.
- Debounces presses and releases.
- Emits one registered key code with a single-cycle valid strobe per press.
- The operand-entry FSM downstream consumes `key_code`/`key_valid` to build `first_num`/`second_num`.

Parameters:
- SCAN_DIV, 27000: clk cycles per column dwell (1 ms at 27 MHz); must be ≥2.
- DEBOUNCE_SCANS, 10: consecutive matching scan ticks required to accept a press or a release; must be ≥1.
- REPEAT_DELAY, 500: scan ticks held before the first auto-repeat (used only with KEY_REPEAT_EN).
- REPEAT_RATE, 100: scan ticks between auto-repeats (used only with KEY_REPEAT_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- row  in  4  keypad rows, active-low, pulled up externally, asynchronous to clk
- column  out  4  column drive, active-low one-hot
- key_code  out  4  last accepted key
- key_valid  out  1  one-cycle strobe; key_code is new/valid this cycle
- key_held  out  1  high while an accepted key is still pressed

Behaviour:
- Reset (rst=0, async):
  - column=4'b1110, key_code=0, key_valid=0, key_held=0.
  - Row synchronizer=4'b1111, all counters=0, state=SCAN.
  - Reset mid-press aborts immediately. The same key is re-detected from scratch after reset is released.
- Row input: 2-FF synchronizer. All decisions use the synchronized value `row_s`.
- Tick: a divider counts 0..SCAN_DIV-1. `tick` is high for one cycle when the count equals SCAN_DIV-1. The divider free-runs in every state.
- Key map, row index r and column index c = position of the low bit:
  - r0: 1,2,3,A(10)
  - r1: 4,5,6,B(11)
  - r2: 7,8,9,C(12)
  - r3: *(14),0,#(15),D(13)
- FSM:
  - SCAN:
    - On tick with row_s==1111 or with more than one low bit: rotate column left (1110→1101→1011→0111→1110) and stay.
    - On tick with exactly one low bit: latch row pattern and candidate code, clear debounce count, go to DEBOUNCE. Column does not rotate.
  - DEBOUNCE (column frozen):
    - On tick with row_s == latched pattern: count++.
    - When count reaches DEBOUNCE_SCANS: key_code<=candidate, key_valid<=1 (registered, the cycle after that tick), key_held<=1, go to HELD.
    - On tick with a mismatch: go to SCAN and rotate column.
  - HELD (column frozen):
    - On tick with row_s==1111: release count++. Any non-1111 tick clears the release count.
    - Release count reaching DEBOUNCE_SCANS: key_held<=0, rotate column, go to SCAN.
- Rules that hold in all states:
  - key_valid is never high two consecutive cycles.
  - key_code holds its value after release until the next accepted press.
  - Only one key is reported per press. A second key pressed while HELD is ignored.
  - Counters saturate, never wrap.
  - With DEBOUNCE_SCANS=1, the first confirming tick accepts the press.

Optional Feature:
- Macro KEY_REPEAT_EN.
- Defined:
  - In HELD, a repeat counter counts ticks.
  - At REPEAT_DELAY ticks, and every REPEAT_RATE ticks after that, key_valid pulses with the unchanged key_code.
  - The counter clears on entry to HELD and whenever the release count is nonzero.
- Undefined: repeat logic is absent; exactly one key_valid per press.

Decomposition:
- Package keypad_pkg:
  - `scan_state_t` enum (SCAN, DEBOUNCE, HELD).
  - Key constants KEY_A=4'd10, KEY_B=4'd11, KEY_C=4'd12, KEY_D=4'd13, KEY_STAR=4'd14, KEY_HASH=4'd15.
  - Function `key_decode(row_idx, col_idx)` returning the 4-bit code.
  - Constant COL_RESET=4'b1110.
- Sub-module module_scan_tick: the parameterised divider producing `tick`, with async active-low reset.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3):
1. Reset held, then released:
   - column=1110, all outputs 0.
   - With no key pressed, column rotates every 4 cycles through 1101, 1011, 0111, 1110.
2. Key 5 (r1,c1) held clean:
   - Column freezes at 1101.
   - After 3 matching ticks: one-cycle key_valid with key_code=5, key_held=1.
   - After release: 3 idle ticks, then key_held=0 and scanning resumes.
3. Bouncing press (row toggles on alternate ticks):
   - No key_valid.
   - FSM returns to SCAN on each mismatch.
   - A stable press afterwards yields exactly one key_valid.
4. Key A held, then key B pressed during HELD:
   - Single key_valid with key_code=10; key B ignored.
   - After A is released and B pressed alone: key_valid with key_code=11.
5. Two rows low on the same column (ghost):
   - No key_valid; column keeps rotating.
6. rst asserted during DEBOUNCE of key 9:
   - Outputs clear immediately, no key_valid.
   - After rst=1 with key 9 still held: key_code=9 is accepted after a full debounce.
   - With KEY_REPEAT_EN, REPEAT_DELAY=5, REPEAT_RATE=2: holding key 0 gives pulses at HELD ticks 5, 7, 9.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } scan_state_t;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  localparam logic [3:0] COL_RESET = 4'b1110;

  function automatic logic [3:0] key_decode(input logic [1:0] row_idx, input logic [1:0] col_idx);
    logic [3:0] code;
    case ({row_idx, col_idx})
      4'h0:    code = 4'd1;
      4'h1:    code = 4'd2;
      4'h2:    code = 4'd3;
      4'h3:    code = KEY_A;
      4'h4:    code = 4'd4;
      4'h5:    code = 4'd5;
      4'h6:    code = 4'd6;
      4'h7:    code = KEY_B;
      4'h8:    code = 4'd7;
      4'h9:    code = 4'd8;
      4'hA:    code = 4'd9;
      4'hB:    code = KEY_C;
      4'hC:    code = KEY_STAR;
      4'hD:    code = 4'd0;
      4'hE:    code = KEY_HASH;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/module_scan_tick.sv
// Free-running column dwell divider; tick is high during the last count.
module module_scan_tick #(
  parameter int unsigned SCAN_DIV = 27000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned W = $clog2(SCAN_DIV);
  localparam logic [W-1:0] LAST = W'(SCAN_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/module_keypad_scanner.sv
// 4x4 keypad column scanner with press/release debounce and one-cycle key strobe.
// Optional auto-repeat while held is enabled by defining KEY_REPEAT_EN.
module module_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 27000,
  parameter int unsigned DEBOUNCE_SCANS = 10,
  parameter int unsigned REPEAT_DELAY   = 500,
  parameter int unsigned REPEAT_RATE    = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] column,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  if (SCAN_DIV < 2 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("module_keypad_scanner: illegal parameter value");
  end

  localparam int unsigned DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_SCANS - 1);

  logic [3:0]    row_m, row_s, row_low;
  logic          tick, single_low;
  logic [1:0]    row_idx, col_idx;
  logic [3:0]    col_rot;
  scan_state_t   state, state_n;
  logic [3:0]    column_n, key_code_n, cand, cand_n, pat, pat_n;
  logic          key_valid_n, key_held_n;
  logic [DW-1:0] db_cnt, db_cnt_n, rel_cnt, rel_cnt_n;

`ifdef KEY_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW = $clog2(REP_MAX + 1);
  localparam logic [RW-1:0] REP_DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_RATE_LAST  = RW'(REPEAT_RATE - 1);
  logic [RW-1:0] rep_cnt, rep_cnt_n;
  logic          rep_armed, rep_armed_n;
`endif

  module_scan_tick #(.SCAN_DIV(SCAN_DIV)) u_scan_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_m <= '1;
      row_s <= '1;
    end else begin
      row_m <= row;
      row_s <= row_m;
    end
  end

  always_comb begin
    row_low    = ~row_s;
    single_low = (row_low != '0) && ((row_low & (row_low - 4'd1)) == '0);
    col_rot    = {column[2:0], column[3]};
    row_idx    = '0;
    col_idx    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (row_low[i]) row_idx = 2'(i);
      if (!column[i]) col_idx = 2'(i);
    end
  end

  always_comb begin
    state_n     = state;
    column_n    = column;
    key_code_n  = key_code;
    key_valid_n = 1'b0;
    key_held_n  = key_held;
    cand_n      = cand;
    pat_n       = pat;
    db_cnt_n    = db_cnt;
    rel_cnt_n   = rel_cnt;
`ifdef KEY_REPEAT_EN
    rep_cnt_n   = rep_cnt;
    rep_armed_n = rep_armed;
`endif
    unique case (state)
      SCAN: begin
        if (tick) begin
          if (single_low) begin
            pat_n    = row_s;
            cand_n   = key_decode(row_idx, col_idx);
            db_cnt_n = '0;
            state_n  = DEBOUNCE;
          end else begin
            column_n = col_rot;
          end
        end
      end
      DEBOUNCE: begin
        if (tick) begin
          if (row_s == pat) begin
            if (db_cnt >= DB_LAST) begin
              key_code_n  = cand;
              key_valid_n = 1'b1;
              key_held_n  = 1'b1;
              rel_cnt_n   = '0;
              state_n     = HELD;
`ifdef KEY_REPEAT_EN
              rep_cnt_n   = '0;
              rep_armed_n = 1'b0;
`endif
            end else begin
              db_cnt_n = db_cnt + DW'(1);
            end
          end else begin
            column_n = col_rot;
            state_n  = SCAN;
          end
        end
      end
      HELD: begin
        if (tick) begin
          if (row_s == '1) begin
            if (rel_cnt >= DB_LAST) begin
              key_held_n = 1'b0;
              rel_cnt_n  = '0;
              column_n   = col_rot;
              state_n    = SCAN;
            end else begin
              rel_cnt_n = rel_cnt + DW'(1);
            end
          end else begin
            rel_cnt_n = '0;
          end
        end
`ifdef KEY_REPEAT_EN
        // A tick that sees the keypad idle never repeats, so a release cannot emit a stray strobe.
        if (rel_cnt != '0) begin
          rep_cnt_n   = '0;
          rep_armed_n = 1'b0;
        end else if (tick && row_s != '1) begin
          if (!rep_armed && rep_cnt >= REP_DELAY_LAST) begin
            key_valid_n = 1'b1;
            rep_armed_n = 1'b1;
            rep_cnt_n   = '0;
          end else if (rep_armed && rep_cnt >= REP_RATE_LAST) begin
            key_valid_n = 1'b1;
            rep_cnt_n   = '0;
          end else begin
            rep_cnt_n = rep_cnt + RW'(1);
          end
        end
`endif
      end
      default: state_n = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SCAN;
      column    <= COL_RESET;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      cand      <= '0;
      pat       <= '1;
      db_cnt    <= '0;
      rel_cnt   <= '0;
`ifdef KEY_REPEAT_EN
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      column    <= column_n;
      key_code  <= key_code_n;
      key_valid <= key_valid_n;
      key_held  <= key_held_n;
      cand      <= cand_n;
      pat       <= pat_n;
      db_cnt    <= db_cnt_n;
      rel_cnt   <= rel_cnt_n;
`ifdef KEY_REPEAT_EN
      rep_cnt   <= rep_cnt_n;
      rep_armed <= rep_armed_n;
`endif
    end
  end

endmodule

// File: tb/tb_module_keypad_scanner.sv
// Directed bench for module_keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3 and a keypad matrix model.
module tb_module_keypad_scanner;

`ifdef KEY_REPEAT_EN
  localparam int unsigned RD = 5;
  localparam int unsigned RR = 2;
`else
  localparam int unsigned RD = 500;
  localparam int unsigned RR = 100;
`endif

  logic        clk;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  column;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] keys;
  logic        bounce;
  int          cyc;
  int          total;
  int          passed;
  int          vcount;
  int          exp_v;
  int          dbl;
  logic        prev_valid;
  logic [3:0]  exp_col;

  module_keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .column    (column),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key index is row*4 + col; a row reads low only while its pressed key's column is driven.
  always_comb begin
    row = 4'b1111;
    for (int unsigned r = 0; r < 4; r++)
      for (int unsigned c = 0; c < 4; c++)
        if (keys[r*4+c] && !column[c] && !bounce) row[r] = 1'b0;
  end

  initial begin
    vcount = 0;
    dbl = 0;
    prev_valid = 1'b0;
  end

  always @(posedge clk) begin
    if (key_valid) vcount++;
    if (key_valid && prev_valid) dbl++;
    prev_valid = key_valid;
  end

  function automatic logic [3:0] rotl(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
    cyc += n;
  endtask

  task automatic next_tick();
    clk_n(4 - (cyc % 4));
  endtask

  task automatic ticks(input int n);
    for (int unsigned i = 0; i < n; i++) next_tick();
  endtask

  task automatic expect_accept(input int n, input logic [3:0] code, input string tag);
    for (int unsigned i = 0; i + 1 < n; i++) begin
      next_tick();
      chk({tag, "_no_early_valid"}, 32'(key_valid), 32'd0);
    end
    next_tick();
    chk({tag, "_valid"}, 32'(key_valid), 32'd1);
    chk({tag, "_code"}, 32'(key_code), 32'(code));
    chk({tag, "_held"}, 32'(key_held), 32'd1);
    exp_v++;
    clk_n(1);
    chk({tag, "_valid_one_cycle"}, 32'(key_valid), 32'd0);
  endtask

  task automatic expect_release(input logic [3:0] col_after, input logic [3:0] code, input string tag);
    keys = '0;
    next_tick();
    next_tick();
    chk({tag, "_still_held"}, 32'(key_held), 32'd1);
    next_tick();
    chk({tag, "_released"}, 32'(key_held), 32'd0);
    chk({tag, "_col_resumes"}, 32'(column), 32'(col_after));
    chk({tag, "_code_kept"}, 32'(key_code), 32'(code));
  endtask

  initial begin
    total = 0;
    passed = 0;
    exp_v = 0;
    cyc = 0;
    keys = '0;
    bounce = 1'b0;
    rst = 1'b0;

    // 1: reset values, then idle rotation every 4 cycles
    clk_n(3);
    chk("rst_column", 32'(column), 32'hE);
    chk("rst_code", 32'(key_code), 32'd0);
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_held", 32'(key_held), 32'd0);
    rst = 1'b1;
    cyc = 0;
    clk_n(3);
    chk("idle_col_dwell", 32'(column), 32'hE);
    clk_n(1);
    chk("idle_col_1101", 32'(column), 32'hD);
    next_tick();
    chk("idle_col_1011", 32'(column), 32'hB);
    next_tick();
    chk("idle_col_0111", 32'(column), 32'h7);
    next_tick();
    chk("idle_col_1110", 32'(column), 32'hE);

    // 2: key 5 clean press from column 0
    keys[5] = 1'b1;
    expect_accept(5, 4'd5, "key5");
    chk("key5_col_frozen", 32'(column), 32'hD);
    expect_release(4'b1011, 4'd5, "key5");

    // 5: ghost on column 2 rows 0 and 1 keeps rotating
    keys[2] = 1'b1;
    keys[6] = 1'b1;
    exp_col = 4'b1011;
    for (int unsigned i = 0; i < 8; i++) begin
      next_tick();
      exp_col = rotl(exp_col);
      chk("ghost_rotate", 32'(column), 32'(exp_col));
    end
    chk("ghost_no_valid", 32'(vcount), 32'(exp_v));
    keys = '0;

    // 3: key 3 bouncing, then stable
    keys[2] = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      bounce = 1'b0;
      next_tick();
      chk("bounce_col_frozen", 32'(column), 32'hB);
      bounce = 1'b1;
      next_tick();
      chk("bounce_back_to_scan", 32'(column), 32'h7);
      bounce = 1'b0;
      ticks(3);
    end
    chk("bounce_no_valid", 32'(vcount), 32'(exp_v));
    expect_accept(4, 4'd3, "key3");
    expect_release(4'b0111, 4'd3, "key3");

    // 4: A held, B added during HELD is ignored; B alone later is accepted
    keys[3] = 1'b1;
    expect_accept(4, 4'd10, "keyA");
    keys[7] = 1'b1;
    ticks(6);
    chk("keyB_ignored_held", 32'(key_held), 32'd1);
    chk("keyB_ignored_col", 32'(column), 32'h7);
    chk("keyB_ignored_code", 32'(key_code), 32'd10);
    chk("keyB_ignored_count", 32'(vcount), 32'(exp_v));
    expect_release(4'b1110, 4'd10, "keyA");
    keys[7] = 1'b1;
    expect_accept(7, 4'd11, "keyB");
    expect_release(4'b1110, 4'd11, "keyB");

    // 6: reset during debounce of key 9, then full re-detection
    keys[10] = 1'b1;
    ticks(4);
    chk("key9_debouncing_col", 32'(column), 32'hB);
    chk("key9_debouncing_valid", 32'(key_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_column", 32'(column), 32'hE);
    chk("midrst_code", 32'(key_code), 32'd0);
    chk("midrst_held", 32'(key_held), 32'd0);
    clk_n(2);
    rst = 1'b1;
    cyc = 0;
    expect_accept(6, 4'd9, "key9");
    expect_release(4'b0111, 4'd9, "key9");

`ifdef KEY_REPEAT_EN
    // Repeat: key 0 from column 3, strobes at HELD ticks 5, 7, 9
    keys[13] = 1'b1;
    expect_accept(6, 4'd0, "key0");
    for (int unsigned t = 1; t <= 9; t++) begin
      next_tick();
      chk("repeat_valid", 32'(key_valid), (t == 5 || t == 7 || t == 9) ? 32'd1 : 32'd0);
      if (t == 5 || t == 7 || t == 9) exp_v++;
    end
    chk("repeat_code", 32'(key_code), 32'd0);
    expect_release(4'b1011, 4'd0, "key0");
`endif

    clk_n(2);
    chk("total_valid_pulses", 32'(vcount), 32'(exp_v));
    chk("no_back_to_back_valid", 32'(dbl), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
